spi_alu_slave_p: RTL and testbench
==================================

Name: spi_alu_slave_p

Overview:
- Parametrised, system-clocked successor to the team's 3-bit SPI ALU slave.
- Receives a command frame {op, a, b} over SPI (sclk/cs/mosi), computes a W-bit ALU result and shifts it back on miso in the same chip-select window.
- Adds:
  - configurable operand width, SPI mode and bit order;
  - an 8-op set;
  - abort/error detection;
  - system-side done/err/result reporting for a host-side register block.

Parameters:
W, 3, operand width (a, b); result width is W+1
CPOL, 0, sclk idle level
CPHA, 1, 0: sample on leading edge; 1: sample on trailing edge
LSB_FIRST, 1, 1: bit 0 transferred first on both mosi and miso; 0: MSB first
SYNC_STAGES, 2, flops in each sclk/cs/mosi synchroniser (≥2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sclk  in  1  SPI clock, asynchronous to clk
cs  in  1  chip select, active low
mosi  in  1  serial data in
miso  out  1  serial data out
miso_oe  out  1  miso drive enable, high while the frame is active
done  out  1  one-clk pulse on completed frame
err  out  1  one-clk pulse on aborted frame
result  out  W+1  result of the last completed frame

Behaviour:
- Reset (rst_n low, async): state=IDLE; miso=0, miso_oe=0, done=0, err=0, result=0; shift/bit counters=0.
- Synchronisation and edge detection:
  - sclk, cs and mosi pass through SYNC_STAGES flops; edges are detected on the synchronised signals.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1; shift edge = the other edge.
  - Legal only for sclk half-period ≥ SYNC_STAGES+2 clk.
- Frame format: IN_BITS = 3+2W bits in, field order {op[2:0], a[W-1:0], b[W-1:0]} with op most significant. The frame is received LSB first (b[0] first) if LSB_FIRST=1, else MSB first (op[2] first).
- States:
  - IDLE:
    - cs falling → RX; clear counters; miso_oe=1.
  - RX:
    - Each sample edge shifts mosi into the input register and increments bitcnt.
    - bitcnt==IN_BITS → CALC.
    - Shift edges are ignored; miso holds 0.
  - CALC (exactly 1 clk): compute sum (W+1 bits, mod 2^(W+1)) and go to TX. Ops:
    - 000 ADD: a+b
    - 001 SUB: a−b, wraps
    - 010 INV: ~a zero-extended
    - 011 RED: |b
    - 100 AND: a&b
    - 101 OR: a|b
    - 110 XOR: a^b
    - 111 GT: (a>b)
  - TX:
    - Each shift edge drives the next sum bit on miso (bit order per LSB_FIRST).
    - The first bit is driven on the first shift edge after the last input sample.
    - After the W+1-th bit is driven: result<=sum, done pulses for 1 clk, → HOLD.
    - Sample edges are ignored.
  - HOLD:
    - Further sclk edges are ignored; miso stays at the last driven bit.
    - cs rising → IDLE.
- cs rising in RX, CALC or TX:
  - Abort: err pulses 1 clk, result unchanged, → IDLE.
  - miso=0, miso_oe=0 on the next clk.
- cs rising in any state:
  - miso_oe=0 and miso=0 by the next clk.
  - Next cs falling starts a fresh frame; there is no carry-over.
- cs falling while not IDLE cannot occur, since cs must have risen first; a glitch shorter than the synchroniser window is not required to be detected.
- done and err are mutually exclusive and never asserted for the same frame.
- Async reset mid-frame: immediate return to IDLE with all outputs zero; no err pulse.

Test Plan:
- W=3, LSB_FIRST=1, mode CPOL0/CPHA1, op ADD a=3 b=5 → miso bits 0,0,0,1 (sum=4'b1000); done pulse; result=8.
- W=3, op SUB a=2 b=5 → sum=4'b1101 (wrap); then op GT a=6 b=1 → sum=1; result updates after each frame.
- W=8, LSB_FIRST=0, CPOL=1 CPHA=0, op XOR a=8'hA5 b=8'h0F → 19 input bits, miso MSB-first 9'h0AA; done pulse.
- Abort: cs rises after 5 of 9 input bits → err pulse, no done, result holds previous value; next full ADD frame a=1 b=1 → result=2.
- Extra sclk edges after 4 output bits (W=3) → miso holds last bit, no second done; cs rise → miso_oe=0.
- rst_n asserted mid-TX → miso=0, miso_oe=0, result=0 immediately; next frame INV a=3'b010 → sum=4'b0101.

Source files
------------

// File: rtl/spi_alu_slave_p_if.sv
// SPI-side bundle of the ALU slave: serial pins from the master plus the
// system-side completion/result reporting seen by the host register block.
interface spi_alu_slave_p_if #(
  parameter int W = 3
);
  logic         sclk;
  logic         cs;
  logic         mosi;
  logic         miso;
  logic         miso_oe;
  logic         done;
  logic         err;
  logic [W:0]   result;

  modport slave (
    input  sclk, cs, mosi,
    output miso, miso_oe, done, err, result
  );

  modport master (
    output sclk, cs, mosi,
    input  miso, miso_oe, done, err, result
  );
endinterface

// File: rtl/spi_alu_slave_p.sv
// System-clocked SPI ALU slave: receives {op, a, b}, computes a (W+1)-bit
// result in one clk and shifts it back on miso inside the same cs window.
module spi_alu_slave_p #(
  parameter int W           = 3,
  parameter int CPOL        = 0,
  parameter int CPHA        = 1,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_alu_slave_p_if.slave   bus
);

  localparam int IN_BITS = 3 + 2 * W;
  localparam int CW      = $clog2(IN_BITS + 1);
  localparam logic [CW-1:0] LAST_RX = CW'(IN_BITS - 1);
  localparam logic [CW-1:0] LAST_TX = CW'(W);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {IDLE, RX, CALC, TX, HOLD} state_t;

  function automatic logic [W:0] alu(input logic [2:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    logic [W:0] r;
    case (op)
      3'd0:    r = {1'b0, a} + {1'b0, b};
      3'd1:    r = {1'b0, a} - {1'b0, b};
      3'd2:    r = {1'b0, ~a};
      3'd3:    r = {{W{1'b0}}, |b};
      3'd4:    r = {1'b0, a & b};
      3'd5:    r = {1'b0, a | b};
      3'd6:    r = {1'b0, a ^ b};
      default: r = {{W{1'b0}}, (a > b)};
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;
  logic                   cs_prev_q, cs_prev_d;

  state_t                 state_q, state_d;
  logic [CW-1:0]          bitcnt_q, bitcnt_d;
  logic [IN_BITS-1:0]     shreg_q, shreg_d;
  logic [W:0]             sum_q, sum_d;
  logic [W:0]             tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic                   miso_oe_q, miso_oe_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [W:0]             result_q, result_d;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic lead_edge, trail_edge, sample_edge, shift_edge;
  logic [2:0]   op_f;
  logic [W-1:0] a_f, b_f;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign cs_rise     = cs_s & ~cs_prev_q;
  assign cs_fall     = ~cs_s & cs_prev_q;
  assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

  assign op_f = shreg_q[IN_BITS-1 -: 3];
  assign a_f  = shreg_q[2*W-1 -: W];
  assign b_f  = shreg_q[W-1:0];

  assign bus.miso    = miso_q;
  assign bus.miso_oe = miso_oe_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.result  = result_q;

  // Synchroniser chains for the async SPI pins plus one-deep history for edges.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    sclk_prev_d = sclk_s;
    cs_prev_d   = cs_s;
  end

  // Synchroniser registers; reset to idle pin levels so release makes no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_prev_d;
      cs_prev_q   <= cs_prev_d;
    end
  end

  // Frame FSM: cs rise overrides everything; otherwise receive, compute, send.
  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    sum_d     = sum_q;
    tx_d      = tx_q;
    miso_d    = miso_q;
    miso_oe_d = miso_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    result_d  = result_q;
    if (cs_rise) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      miso_oe_d = 1'b0;
      bitcnt_d  = '0;
      if (state_q == RX || state_q == CALC || state_q == TX) err_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d   = RX;
            bitcnt_d  = '0;
            shreg_d   = '0;
            miso_d    = 1'b0;
            miso_oe_d = 1'b1;
          end
        end
        RX: begin
          if (sample_edge) begin
            if (LSB_FIRST != 0) shreg_d = {mosi_s, shreg_q[IN_BITS-1:1]};
            else                shreg_d = {shreg_q[IN_BITS-2:0], mosi_s};
            bitcnt_d = bitcnt_q + CW'(1);
            if (bitcnt_q == LAST_RX) state_d = CALC;
          end
        end
        CALC: begin
          sum_d    = alu(op_f, a_f, b_f);
          tx_d     = alu(op_f, a_f, b_f);
          bitcnt_d = '0;
          state_d  = TX;
        end
        TX: begin
          if (shift_edge) begin
            if (LSB_FIRST != 0) begin
              miso_d = tx_q[0];
              tx_d   = tx_q >> 1;
            end else begin
              miso_d = tx_q[W];
              tx_d   = tx_q << 1;
            end
            bitcnt_d = bitcnt_q + CW'(1);
            if (bitcnt_q == LAST_TX) begin
              result_d = sum_q;
              done_d   = 1'b1;
              state_d  = HOLD;
            end
          end
        end
        HOLD: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Frame state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      sum_q     <= '0;
      tx_q      <= '0;
      miso_q    <= 1'b0;
      miso_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      sum_q     <= sum_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      miso_oe_q <= miso_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_spi_alu_slave_p.sv
// Directed bench for spi_alu_slave_p: a W=3 CPOL0/CPHA1 LSB-first instance
// driven from a vector table, and a W=8 CPOL1/CPHA0 MSB-first instance.
module tb_spi_alu_slave_p;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   done0 = 0, err0 = 0, done1 = 0, err1 = 0;

  logic sclk0, cs0, mosi0, sclk1, cs1, mosi1;

  spi_alu_slave_p_if #(.W(3)) b0 ();
  spi_alu_slave_p_if #(.W(8)) b1 ();

  assign b0.sclk = sclk0;
  assign b0.cs   = cs0;
  assign b0.mosi = mosi0;
  assign b1.sclk = sclk1;
  assign b1.cs   = cs1;
  assign b1.mosi = mosi1;

  spi_alu_slave_p #(.W(3), .CPOL(0), .CPHA(1), .LSB_FIRST(1), .SYNC_STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  spi_alu_slave_p #(.W(8), .CPOL(1), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (b0.done) done0++;
    if (b0.err)  err0++;
    if (b1.done) done1++;
    if (b1.err)  err1++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] op;
    logic [2:0] a;
    logic [2:0] b;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic wait_h();
    repeat (6) @(negedge clk);
  endtask

  task automatic set_sclk(input int sel, input logic v);
    if (sel == 0) sclk0 = v; else sclk1 = v;
  endtask

  task automatic set_cs(input int sel, input logic v);
    if (sel == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic set_mosi(input int sel, input logic v);
    if (sel == 0) mosi0 = v; else mosi1 = v;
  endtask

  function automatic logic rd_miso(input int sel);
    return (sel == 0) ? b0.miso : b1.miso;
  endfunction

  function automatic logic rd_oe(input int sel);
    return (sel == 0) ? b0.miso_oe : b1.miso_oe;
  endfunction

  // Master side of one frame; stop_at<0 runs all nin+nout clock cycles.
  task automatic spi_frame(input int sel, input logic [31:0] frame, input int nin,
                           input int nout, input int stop_at, input int extra,
                           input bit keep_cs, output logic [31:0] got,
                           output logic hold_miso, output logic oe_mid);
    logic cpol, cpha, lsb, bitv;
    int   ncyc;
    cpol = (sel == 1);
    cpha = (sel == 0);
    lsb  = (sel == 0);
    ncyc = (stop_at >= 0) ? stop_at : nin + nout;
    got  = '0;
    set_cs(sel, 1'b0);
    wait_h();
    for (int i = 0; i < ncyc + extra; i++) begin
      bitv = 1'b0;
      if (i < nin) bitv = lsb ? frame[i] : frame[nin-1-i];
      if (!cpha) begin
        set_mosi(sel, bitv);
        wait_h();
        set_sclk(sel, ~cpol);
        if (i >= nin && i < nin + nout) begin
          if (lsb) got[i-nin] = rd_miso(sel);
          else     got[nout-1-(i-nin)] = rd_miso(sel);
        end
        wait_h();
        set_sclk(sel, cpol);
      end else begin
        set_sclk(sel, ~cpol);
        set_mosi(sel, bitv);
        wait_h();
        set_sclk(sel, cpol);
        if (i >= nin && i < nin + nout) begin
          if (lsb) got[i-nin] = rd_miso(sel);
          else     got[nout-1-(i-nin)] = rd_miso(sel);
        end
        wait_h();
      end
    end
    wait_h();
    hold_miso = rd_miso(sel);
    oe_mid    = rd_oe(sel);
    if (!keep_cs) begin
      set_cs(sel, 1'b1);
      wait_h();
      wait_h();
    end
  endtask

  initial begin
    logic [31:0] got;
    logic        hm, oe;
    int          d0, e0, d1, e1;

    vecs[0]  = '{3'd0, 3'd3, 3'd5, 4'd8};
    vecs[1]  = '{3'd1, 3'd2, 3'd5, 4'd13};
    vecs[2]  = '{3'd7, 3'd6, 3'd1, 4'd1};
    vecs[3]  = '{3'd2, 3'd2, 3'd0, 4'd5};
    vecs[4]  = '{3'd3, 3'd7, 3'd0, 4'd0};
    vecs[5]  = '{3'd3, 3'd0, 3'd4, 4'd1};
    vecs[6]  = '{3'd4, 3'd6, 3'd3, 4'd2};
    vecs[7]  = '{3'd5, 3'd4, 3'd1, 4'd5};
    vecs[8]  = '{3'd6, 3'd5, 3'd3, 4'd6};
    vecs[9]  = '{3'd0, 3'd7, 3'd7, 4'd14};
    vecs[10] = '{3'd1, 3'd5, 3'd5, 4'd0};
    vecs[11] = '{3'd7, 3'd1, 3'd6, 4'd0};

    rst_n = 1'b0;
    sclk0 = 1'b0; cs0 = 1'b1; mosi0 = 1'b0;
    sclk1 = 1'b1; cs1 = 1'b1; mosi1 = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_miso",    {31'd0, b0.miso},    32'd0);
    check("reset_miso_oe", {31'd0, b0.miso_oe}, 32'd0);
    check("reset_done",    {31'd0, b0.done},    32'd0);
    check("reset_err",     {31'd0, b0.err},     32'd0);
    check("reset_result",  {28'd0, b0.result},  32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven W=3 frames.
    for (int v = 0; v < 12; v++) begin
      d0 = done0; e0 = err0;
      spi_frame(0, {23'd0, vecs[v].op, vecs[v].a, vecs[v].b}, 9, 4, -1, 0, 1'b0, got, hm, oe);
      check($sformatf("vec%0d_miso", v),   got,                   {28'd0, vecs[v].exp});
      check($sformatf("vec%0d_result", v), {28'd0, b0.result},    {28'd0, vecs[v].exp});
      check($sformatf("vec%0d_done", v),   done0 - d0,            32'd1);
      check($sformatf("vec%0d_err", v),    err0 - e0,             32'd0);
      check($sformatf("vec%0d_oe_mid", v), {31'd0, oe},           32'd1);
    end

    // W=8 MSB-first CPOL1/CPHA0: XOR A5 ^ 0F.
    d1 = done1; e1 = err1;
    spi_frame(1, {13'd0, 3'b110, 8'hA5, 8'h0F}, 19, 9, -1, 0, 1'b0, got, hm, oe);
    check("w8_xor_miso",   got,                 32'h0AA);
    check("w8_xor_result", {23'd0, b1.result},  32'h0AA);
    check("w8_xor_done",   done1 - d1,          32'd1);
    check("w8_xor_err",    err1 - e1,           32'd0);

    // Extra sclk edges after the last output bit: miso holds, single done.
    d0 = done0;
    spi_frame(0, {23'd0, 3'd0, 3'd3, 3'd5}, 9, 4, -1, 3, 1'b0, got, hm, oe);
    check("extra_miso",      got,                  32'd8);
    check("extra_hold_bit",  {31'd0, hm},          32'd1);
    check("extra_done_once", done0 - d0,           32'd1);
    check("extra_oe_after",  {31'd0, b0.miso_oe},  32'd0);
    check("extra_miso_after",{31'd0, b0.miso},     32'd0);
    check("extra_result",    {28'd0, b0.result},   32'd8);

    // Abort after 5 of 9 input bits.
    d0 = done0; e0 = err0;
    spi_frame(0, {23'd0, 3'd0, 3'd1, 3'd1}, 9, 4, 5, 0, 1'b0, got, hm, oe);
    check("abort_err",       err0 - e0,            32'd1);
    check("abort_no_done",   done0 - d0,           32'd0);
    check("abort_result",    {28'd0, b0.result},   32'd8);
    check("abort_oe_after",  {31'd0, b0.miso_oe},  32'd0);

    // Fresh frame after the abort.
    d0 = done0;
    spi_frame(0, {23'd0, 3'd0, 3'd1, 3'd1}, 9, 4, -1, 0, 1'b0, got, hm, oe);
    check("post_abort_result", {28'd0, b0.result}, 32'd2);
    check("post_abort_done",   done0 - d0,         32'd1);

    // Async reset in the middle of TX (ADD 7,7 = 1110, two bits driven).
    e0 = err0; d0 = done0;
    spi_frame(0, {23'd0, 3'd0, 3'd7, 3'd7}, 9, 4, 11, 0, 1'b1, got, hm, oe);
    check("midtx_miso_before", {31'd0, hm}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_miso",    {31'd0, b0.miso},    32'd0);
    check("rst_miso_oe", {31'd0, b0.miso_oe}, 32'd0);
    check("rst_result",  {28'd0, b0.result},  32'd0);
    set_cs(0, 1'b1);
    set_sclk(0, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_err",  err0 - e0,  32'd0);
    check("rst_no_done", done0 - d0, 32'd0);
    spi_frame(0, {23'd0, 3'd2, 3'b010, 3'd0}, 9, 4, -1, 0, 1'b0, got, hm, oe);
    check("post_rst_inv_miso",   got,                32'd5);
    check("post_rst_inv_result", {28'd0, b0.result}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
